instr_exec_unit: RTL and testbench

//   Execute stage downstream of the instruction register. Accepts one decoded

---
 rtl/instr_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_instr_exec_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// rtl/instr_exec_unit.sv - execute stage: 1-cycle ALU ops plus iterative signed MULT/DIV/MOD
// One instruction in flight; results carry the issuing tag and are held under backpressure.
module instr_exec_unit #(
  parameter int OP_W  = 32,
  parameter int RES_W = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opc,
  input  logic [OP_W-1:0]  in_op_a,
  input  logic [OP_W-1:0]  in_op_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             busy
);

  localparam int CNT_W = $clog2(OP_W + 1);
  localparam int EXT_W = RES_W - OP_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_W);
  localparam logic [CNT_W-1:0] CNT_FIN  = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [OP_W-1:0]  work_q, work_d;
  logic             neg_q, mod_q;
  logic [TAG_W-1:0] tag_q;
  logic             out_valid_q, out_err_q;
  logic [RES_W-1:0] out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             out_free, accept, iter, done;
  logic             sign_a, sign_b, go_mul, go_div, imm_err;
  logic [OP_W-1:0]  abs_a, abs_b;
  logic [RES_W-1:0] ext_a, ext_b, imm_res, fin_mag, fin_res;
  logic [OP_W:0]    rem_sh, rem_diff;

  assign out_free   = !out_valid_q || out_ready;
  assign in_ready   = (state_q == S_IDLE) && out_free;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_q == S_MUL) || (state_q == S_DIV);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;

  assign sign_a = in_op_a[OP_W-1];
  assign sign_b = in_op_b[OP_W-1];
  assign abs_a  = sign_a ? -in_op_a : in_op_a;
  assign abs_b  = sign_b ? -in_op_b : in_op_b;
  assign ext_a  = {{EXT_W{sign_a}}, in_op_a};
  assign ext_b  = {{EXT_W{sign_b}}, in_op_b};
  assign go_mul = (in_opc == 4'd5);
  assign go_div = ((in_opc == 4'd6) || (in_opc == 4'd7)) && (in_op_b != '0);

  always_comb begin
    imm_res = '0;
    imm_err = 1'b0;
    case (in_opc)
      4'd0, 4'd5: imm_res = '0;
      4'd1:       imm_res = ext_a;
      4'd2:       imm_res = ext_b;
      4'd3:       imm_res = ext_a + ext_b;
      4'd4:       imm_res = ext_a - ext_b;
      default:    imm_err = 1'b1;
    endcase
  end

  // The last iteration and the result write share a cycle; a blocked write parks at CNT_LAST.
  assign iter     = (cnt_q != CNT_LAST);
  assign done     = (cnt_q == CNT_FIN) || !iter;
  assign rem_sh   = {acc_q[OP_W-1:0], work_q[OP_W-1]};
  assign rem_diff = rem_sh - {1'b0, mcand_q[OP_W-1:0]};

  always_comb begin
    acc_d   = acc_q;
    mcand_d = mcand_q;
    work_d  = work_q;
    if (iter) begin
      if (state_q == S_MUL) begin
        if (work_q[0]) acc_d = acc_q + mcand_q;
        mcand_d = mcand_q << 1;
        work_d  = work_q >> 1;
      end else if (!rem_diff[OP_W]) begin
        acc_d  = {{EXT_W{1'b0}}, rem_diff[OP_W-1:0]};
        work_d = {work_q[OP_W-2:0], 1'b1};
      end else begin
        acc_d  = {{EXT_W{1'b0}}, rem_sh[OP_W-1:0]};
        work_d = {work_q[OP_W-2:0], 1'b0};
      end
    end
    if (state_q == S_MUL) fin_mag = acc_d;
    else if (mod_q)       fin_mag = {{EXT_W{1'b0}}, acc_d[OP_W-1:0]};
    else                  fin_mag = {{EXT_W{1'b0}}, work_d};
    fin_res = neg_q ? -fin_mag : fin_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      mcand_q      <= '0;
      work_q       <= '0;
      neg_q        <= 1'b0;
      mod_q        <= 1'b0;
      tag_q        <= '0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          tag_q <= in_tag;
          cnt_q <= '0;
          acc_q <= '0;
          if (go_mul) begin
            state_q <= S_MUL;
            mcand_q <= {{EXT_W{1'b0}}, abs_a};
            work_q  <= abs_b;
            neg_q   <= sign_a ^ sign_b;
            mod_q   <= 1'b0;
          end else if (go_div) begin
            state_q <= S_DIV;
            mcand_q <= {{EXT_W{1'b0}}, abs_b};
            work_q  <= abs_a;
            mod_q   <= in_opc[0];
            neg_q   <= in_opc[0] ? sign_a : (sign_a ^ sign_b);
          end else begin
            out_valid_q  <= 1'b1;
            out_result_q <= imm_res;
            out_err_q    <= imm_err;
            out_tag_q    <= in_tag;
          end
        end
        S_MUL, S_DIV: begin
          acc_q   <= acc_d;
          mcand_q <= mcand_d;
          work_q  <= work_d;
          if (iter) cnt_q <= cnt_q + 1'b1;
          if (done && out_free) begin
            out_valid_q  <= 1'b1;
            out_result_q <= fin_res;
            out_err_q    <= 1'b0;
            out_tag_q    <= tag_q;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb/tb_instr_exec_unit.sv - bench for instr_exec_unit
// Vector table plus random model vectors through a scoreboard queue, then latency/backpressure/reset sequences.
module tb_instr_exec_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opc = '0;
  logic [31:0] in_op_a = '0;
  logic [31:0] in_op_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;
  logic        busy;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  tag;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        err;
  } vec_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   n_vec = 0;
  int   n_bad = 0;

  instr_exec_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .in_op_a(in_op_a), .in_op_b(in_op_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {out_err, out_tag, out_result}, 72'd0);
      end else begin
        got_e = exp_q.pop_front();
        chk("result", {out_err, out_tag, out_result}, {got_e.err, got_e.tag, got_e.res});
      end
    end
  end

  function automatic logic [64:0] model(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic   e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    e  = 1'b0;
    case (opc)
      4'd0: r = 0;
      4'd1: r = sa;
      4'd2: r = sb;
      4'd3: r = sa + sb;
      4'd4: r = sa - sb;
      4'd5: r = sa * sb;
      4'd6: if (b == 0) e = 1'b1; else r = sa / sb;
      4'd7: if (b == 0) e = 1'b1; else r = sa % sb;
      default: e = 1'b1;
    endcase
    return {e, r};
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input logic [63:0] res, input logic err);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_opc   = opc;
    in_op_a  = a;
    in_op_b  = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {71'd0, in_ready}, 72'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back('{res, tag, err});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 300) begin
      @(negedge clk);
      #1 t++;
    end
    if (t >= 300) begin
      chk("drain_timeout", 72'(exp_q.size()), 72'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input string name, input logic [3:0] opc, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] res,
                          input int exp_lat, input int exp_busy);
    int lat, nbusy, nready;
    lat = 0; nbusy = 0; nready = 0;
    send(opc, a, b, 5'd21, res, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (busy) nbusy++;
      if (in_ready) nready++;
    end
    chk({name, "_latency"}, 72'(lat), 72'(exp_lat));
    chk({name, "_busy_cycles"}, 72'(nbusy), 72'(exp_busy));
    chk({name, "_in_ready_while_busy"}, 72'(nready), 72'd0);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    vec_t        vt[22];
    logic [64:0] m;
    logic [31:0] ra, rb;
    logic [3:0]  ro;
    int          bad;

    vt[0]  = '{4'd3, -32'd15, 32'd7, -64'd8, 1'b0};
    vt[1]  = '{4'd0, 32'd5, 32'd6, 64'd0, 1'b0};
    vt[2]  = '{4'd1, -32'd1, 32'd3, -64'd1, 1'b0};
    vt[3]  = '{4'd2, 32'd1, 32'h7FFF_FFFF, 64'h7FFF_FFFF, 1'b0};
    vt[4]  = '{4'd4, 32'd5, 32'd9, -64'd4, 1'b0};
    vt[5]  = '{4'd5, -32'd15, 32'd15, -64'd225, 1'b0};
    vt[6]  = '{4'd5, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0};
    vt[7]  = '{4'd5, 32'h7FFF_FFFF, -32'd1, -64'd2147483647, 1'b0};
    vt[8]  = '{4'd6, -32'd15, 32'd4, -64'd3, 1'b0};
    vt[9]  = '{4'd7, -32'd15, 32'd4, -64'd3, 1'b0};
    vt[10] = '{4'd6, 32'h8000_0000, -32'd1, 64'h8000_0000, 1'b0};
    vt[11] = '{4'd7, 32'd7, -32'd3, 64'd1, 1'b0};
    vt[12] = '{4'd6, 32'd7, -32'd3, -64'd2, 1'b0};
    vt[13] = '{4'd6, 32'd7, 32'd0, 64'd0, 1'b1};
    vt[14] = '{4'd7, 32'd7, 32'd0, 64'd0, 1'b1};
    vt[15] = '{4'd9, 32'd3, 32'd4, 64'd0, 1'b1};
    vt[16] = '{4'd15, 32'd3, 32'd4, 64'd0, 1'b1};
    vt[17] = '{4'd3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFE, 1'b0};
    vt[18] = '{4'd4, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_7FFF_FFFF, 1'b0};
    vt[19] = '{4'd5, 32'd0, -32'd7, 64'd0, 1'b0};
    vt[20] = '{4'd6, 32'd3, 32'd7, 64'd0, 1'b0};
    vt[21] = '{4'd7, 32'd3, -32'd7, 64'd3, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {56'd0, out_valid, busy, out_err, out_tag, out_result[8:0]}, 72'd0);
    chk("reset_result", {8'd0, out_result}, 72'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {70'd0, in_ready, busy}, 72'd2);
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++)
      send(vt[i].opc, vt[i].a, vt[i].b, 5'(i), vt[i].res, vt[i].err);
    drain();

    for (int i = 0; i < 12; i++) begin
      ro = 4'($urandom_range(0, 8));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) rb = -rb;
      m = model(ro, ra, rb);
      send(ro, ra, rb, 5'(i + 8), m[63:0], m[64]);
    end
    drain();

    lat_test("add", 4'd3, 32'd2, 32'd3, 64'd5, 1, 0);
    lat_test("mult", 4'd5, -32'd15, 32'd15, -64'd225, 33, 32);
    lat_test("div", 4'd6, 32'd100, 32'd7, 64'd14, 33, 32);

    out_ready = 1'b0;
    send(4'd4, 32'd5, 32'd9, 5'd9, -64'd4, 1'b0);
    @(negedge clk);
    chk("bp_first", {out_valid, out_err, out_tag, out_result}, {2'b10, 5'd9, -64'd4});
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(out_valid && out_result == -64'd4 && out_tag == 5'd9 && !out_err && !in_ready)) bad++;
    end
    chk("bp_hold", 72'(bad), 72'd0);
    chk("bp_pending", 72'(exp_q.size()), 72'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_popped", 72'(exp_q.size()), 72'd0);
    @(negedge clk);
    chk("bp_once", {71'd0, out_valid}, 72'd0);
    @(posedge clk);
    #1;

    send(4'd6, 32'd100, 32'd7, 5'd4, 64'd14, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("reset_mid_div", {69'd0, busy, out_valid, in_ready}, 72'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    send(4'd3, 32'd1, 32'd1, 5'd6, 64'd2, 1'b0);
    drain();
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("no_stale_result", 72'(bad), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
